// File: rtl/scan_addr_gen.sv
// -----------------------------------------------------------------------------
// scan_addr_gen
//
// Sequential address scanner driving the 4-bit ADDR input of a 4-to-16
// decoder. Steps through 0..LAST, holding each address DWELL+1 cycles, in
// continuous or single-pass mode, with start/stop control and WRAP/DONE
// pulses. ACTIVE qualifies ADDR for downstream use with the decoder outputs.
//
// Optional feature macro: SCAN_BLANK_EN
//   When defined, every address change (including the wrap to 0) is preceded
//   by one BLANK cycle that holds the old ADDR with ACTIVE=0, which keeps
//   adjacent rows from ghosting. The end of a single pass skips the blank.
//
// Parameters
//   DWELL_W : width of DWELL and of the internal dwell counter
//
// Ports
//   CLK    in   clock, rising edge
//   RST    in   synchronous active-high reset
//   START  in   begin a scan (only honoured in IDLE)
//   STOP   in   abort the scan, wins over START
//   MODE   in   0 = continuous, 1 = single pass (latched at start)
//   LAST   in   final address of a pass (latched at start)
//   DWELL  in   hold count, each address lasts DWELL+1 cycles (latched)
//   ADDR   out  current scan address
//   ACTIVE out  ADDR valid
//   BUSY   out  scan in progress (SCAN or BLANK)
//   WRAP   out  one-cycle pulse when a pass completes
//   DONE   out  one-cycle pulse when a single pass ends
// -----------------------------------------------------------------------------
module scan_addr_gen #(
    parameter int DWELL_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               START,
    input  logic               STOP,
    input  logic               MODE,
    input  logic [3:0]         LAST,
    input  logic [DWELL_W-1:0] DWELL,
    output logic [3:0]         ADDR,
    output logic               ACTIVE,
    output logic               BUSY,
    output logic               WRAP,
    output logic               DONE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         addr_reg, addr_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic               active_reg, active_next;
    logic               busy_reg, busy_next;
    logic               wrap_reg, wrap_next;
    logic               done_reg, done_next;
    logic               mode_lat_reg, mode_lat_next;
    logic [3:0]         last_lat_reg, last_lat_next;
    logic [DWELL_W-1:0] dwell_lat_reg, dwell_lat_next;

    logic dwell_end;
    logic at_last;
    logic [3:0] addr_step;

    assign dwell_end = (cnt_reg == dwell_lat_reg);
    assign at_last   = (addr_reg == last_lat_reg);
    // The 4-bit add wraps 15->0 on its own, but the explicit select also
    // covers LAST < 15.
    assign addr_step = at_last ? 4'd0 : addr_reg + 4'd1;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= IDLE;
            addr_reg      <= 4'd0;
            cnt_reg       <= '0;
            active_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            wrap_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mode_lat_reg  <= 1'b0;
            last_lat_reg  <= 4'd0;
            dwell_lat_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            cnt_reg       <= cnt_next;
            active_reg    <= active_next;
            busy_reg      <= busy_next;
            wrap_reg      <= wrap_next;
            done_reg      <= done_next;
            mode_lat_reg  <= mode_lat_next;
            last_lat_reg  <= last_lat_next;
            dwell_lat_reg <= dwell_lat_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (START && !STOP) state_next = SCAN;
            end
            SCAN: begin
                if (STOP) begin
                    state_next = IDLE;
                end else if (dwell_end) begin
                    if (at_last && mode_lat_reg) state_next = IDLE;
`ifdef SCAN_BLANK_EN
                    else state_next = BLANK;
`endif
                end
            end
            BLANK: begin
                state_next = STOP ? IDLE : SCAN;
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered-output / datapath next values
    always_comb begin
        addr_next      = addr_reg;
        cnt_next       = cnt_reg;
        active_next    = active_reg;
        busy_next      = busy_reg;
        wrap_next      = 1'b0;
        done_next      = 1'b0;
        mode_lat_next  = mode_lat_reg;
        last_lat_next  = last_lat_reg;
        dwell_lat_next = dwell_lat_reg;
        case (state_reg)
            IDLE: begin
                addr_next   = 4'd0;
                cnt_next    = '0;
                active_next = 1'b0;
                busy_next   = 1'b0;
                if (START && !STOP) begin
                    mode_lat_next  = MODE;
                    last_lat_next  = LAST;
                    dwell_lat_next = DWELL;
                    active_next    = 1'b1;
                    busy_next      = 1'b1;
                end
            end
            SCAN: begin
                if (STOP) begin
                    addr_next   = 4'd0;
                    cnt_next    = '0;
                    active_next = 1'b0;
                    busy_next   = 1'b0;
                end else if (dwell_end) begin
                    // Clearing on match keeps the counter from ever
                    // overflowing, even with DWELL at its maximum.
                    cnt_next = '0;
                    if (at_last && mode_lat_reg) begin
                        addr_next   = 4'd0;
                        active_next = 1'b0;
                        busy_next   = 1'b0;
                        wrap_next   = 1'b1;
                        done_next   = 1'b1;
                    end else begin
`ifdef SCAN_BLANK_EN
                        // Hold the old address dark for one cycle; the
                        // address advances when BLANK exits.
                        active_next = 1'b0;
                        wrap_next   = at_last;
`else
                        addr_next   = addr_step;
                        wrap_next   = at_last;
`endif
                    end
                end else begin
                    cnt_next = cnt_reg + DWELL_W'(1);
                end
            end
            BLANK: begin
                cnt_next = '0;
                if (STOP) begin
                    addr_next   = 4'd0;
                    active_next = 1'b0;
                    busy_next   = 1'b0;
                end else begin
                    addr_next   = addr_step;
                    active_next = 1'b1;
                end
            end
            default: begin
                addr_next   = 4'd0;
                cnt_next    = '0;
                active_next = 1'b0;
                busy_next   = 1'b0;
            end
        endcase
    end

    assign ADDR   = addr_reg;
    assign ACTIVE = active_reg;
    assign BUSY   = busy_reg;
    assign WRAP   = wrap_reg;
    assign DONE   = done_reg;

endmodule

// File: doc/scan_addr_gen.md
# scan_addr_gen

Sequential address scanner that drives the 4-bit `ADDR` input of the 4-to-16 decoder. It steps through addresses 0..`LAST`, holding each one for a programmable dwell time. Scans run either continuously or as a single pass, with start/stop control and wrap/done pulses for the surrounding control logic. `ACTIVE` qualifies `ADDR`; downstream logic ANDs it with the decoder's `DEC` outputs, for example for LED-matrix row scanning or keypad column strobing.

## Interface
- `DWELL_W`, default 8: width of the dwell-count input and the internal dwell counter.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `START`  in  1  begin a scan; sampled only in IDLE.
- `STOP`  in  1  abort the scan; takes priority over `START`.
- `MODE`  in  1  0 = continuous, 1 = single pass; latched at start.
- `LAST`  in  4  final address of the pass; latched at start.
- `DWELL`  in  DWELL_W  each address is held `DWELL`+1 cycles; latched at start.
- `ADDR`  out  4  current scan address, to the decoder.
- `ACTIVE`  out  1  `ADDR` is valid and the decoder output may be used.
- `BUSY`  out  1  a scan is in progress (SCAN or BLANK state).
- `WRAP`  out  1  one-cycle pulse when a pass completes.
- `DONE`  out  1  one-cycle pulse when a single pass ends.

## Operation
- **Reset.** `RST`=1 at an edge forces the following, regardless of state or of any other input:
  - state = IDLE;
  - `ADDR`=0, `ACTIVE`=0, `BUSY`=0, `WRAP`=0, `DONE`=0;
  - dwell counter = 0.
- **States.** IDLE, SCAN, BLANK. BLANK exists only with `SCAN_BLANK_EN`.
- **IDLE.**
  - If `START`=1 and `STOP`=0: latch `MODE`, `LAST` and `DWELL`, then go to SCAN with `ADDR`=0, counter=0, `ACTIVE`=1, `BUSY`=1.
  - If `START`=1 and `STOP`=1 in the same cycle: remain in IDLE.
- **SCAN.**
  - The counter increments each cycle.
  - When counter == latched `DWELL`, the address period ends and the counter clears.
  - If `ADDR` != latched `LAST`, the next address is `ADDR`+1.
  - If `ADDR` == latched `LAST` and `MODE`=0: `WRAP` pulses and the next address is 0.
  - If `ADDR` == latched `LAST` and `MODE`=1: `WRAP` and `DONE` both pulse, and the block goes to IDLE with `ADDR`=0, `ACTIVE`=0, `BUSY`=0.
- **STOP.** `STOP`=1 in SCAN or BLANK sends the block to IDLE at the next edge with `ADDR`=0, `ACTIVE`=0, `BUSY`=0. No `WRAP` or `DONE` is generated.
- **START while BUSY** is ignored. Changes to `MODE`, `LAST` or `DWELL` during a scan have no effect.
- **Boundaries.**
  - `LAST`=15: the address wraps 15→0 naturally, with no overflow beyond 4 bits.
  - `LAST`=0: `ADDR` stays at 0 and `WRAP` pulses every `DWELL`+1 cycles.
  - `DWELL`=0: the address changes every cycle.
  - `DWELL` at its maximum (2^`DWELL_W`−1): hold time is 2^`DWELL_W` cycles, and the counter never overflows.
- **Priority:** `RST` > `STOP` > dwell expiry > `START`.

## Timing
- All outputs are registered.
- With `START` sampled at edge k, `ADDR`=0 and `ACTIVE`=1 are visible from edge k onward (latency 1).
- Each address is presented for exactly `DWELL`+1 cycles with `ACTIVE`=1.
- Without blanking, one pass takes (`LAST`+1)×(`DWELL`+1) cycles.
- `WRAP` is high for exactly the one cycle in which the first post-pass state is visible: `ADDR`=0 in continuous mode, or IDLE in single-pass mode.
- `DONE` is coincident with `BUSY` falling.
- A `STOP` or `RST` applied at edge k takes effect from edge k, with no further address change.

## Configuration
- The macro is `SCAN_BLANK_EN`.
- **Defined:** on every address change, including the wrap to 0, the block first spends one cycle in BLANK.
  - BLANK holds the old `ADDR`, with `ACTIVE`=0 and `BUSY`=1.
  - The new `ADDR` and `ACTIVE`=1 follow at the next edge.
  - In continuous mode, `WRAP` pulses in the BLANK cycle.
  - The end of a single pass goes directly to IDLE, with no blank.
  - One pass then takes (`LAST`+1)×(`DWELL`+2)−1 cycles.
  - This blanking suppresses ghosting between rows.
- **Undefined:** BLANK is absent and addresses change back-to-back.

## Test plan
- **Continuous scan.** `DWELL`=2, `LAST`=3, `MODE`=0, `START` pulse.
  - `ADDR` = 0,0,0,1,1,1,2,2,2,3,3,3,0,... with `ACTIVE`=1.
  - `WRAP`=1 only on the cycle `ADDR` returns to 0.
- **Single pass.** Same settings with `MODE`=1.
  - 12 active cycles, then `DONE`=`WRAP`=1 for one cycle.
  - `BUSY`=0, `ACTIVE`=0, `ADDR`=0 afterwards.
  - `START` issued again is accepted.
- **Stop mid-scan.** `STOP` asserted while `ADDR`=2.
  - Next cycle: `ADDR`=0, `ACTIVE`=0, `BUSY`=0; `DONE` and `WRAP` remain 0.
  - A same-cycle `START` and `STOP` in IDLE leaves `BUSY`=0.
- **Full range and boundary cases.** `DWELL`=0, `LAST`=15.
  - `ADDR` counts 0..15 on consecutive cycles, then returns to 0 with `WRAP` every 16 cycles.
  - With `LAST`=0, `ADDR` stays 0 and `WRAP` pulses every cycle.
- **Reset and latching.** `RST` asserted mid-scan at `ADDR`=7.
  - All outputs reach their reset values at the next edge.
  - Changing `DWELL` or `LAST` during a scan does not alter the running sequence.
- **Blanking (`SCAN_BLANK_EN` defined).** `DWELL`=1, `LAST`=1, `MODE`=0.
  - `ACTIVE` pattern 1,1,0,1,1,0,... with `ADDR` 0,0,0,1,1,1,0,...
  - `WRAP` pulses in the blank cycle after address 1.
